bk_adder_pipe: RTL

//  Parametrised, pipelined Brent-Kung adder/subtractor with valid/ready handshake on both sides.

---
 rtl/bk_adder_pipe_pkg.sv | 33 +++
 rtl/bk_prefix_tree.sv | 58 +++++
 rtl/bk_adder_pipe.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/bk_adder_pipe_pkg.sv
// Shared definitions for the pipelined Brent-Kung adder/subtractor.
// Holds the operation encoding, a constant log2 helper, the width legality
// check and the prefix (group generate/propagate) combine operator.
package bk_adder_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Legal operand widths: powers of two from 4 to 128.
  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= 128) && ((w & (w - 1)) == 0);
  endfunction

  // Prefix operator: high group (gh,ph) absorbs low group (gl,pl).
  // Returns {G, P}.
  function automatic logic [1:0] pg_op(input logic gh, input logic ph,
                                       input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung prefix tree, split at the up-sweep/down-sweep
// boundary so the parent can place a register between the two halves.
// Up-sweep: log2(WIDTH) levels; down-sweep: log2(WIDTH)-1 levels.
module bk_prefix_tree
  import bk_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_up,
  output logic [WIDTH-1:0] p_up,
  input  logic [WIDTH-1:0] g_mid,
  input  logic [WIDTH-1:0] p_mid,
  output logic [WIDTH-1:0] g_pre,
  output logic [WIDTH-1:0] p_pre
);

  localparam int LVLS = clog2(WIDTH);

  // Up-sweep: at level l, every position with (i+1) a multiple of 2^(l+1)
  // absorbs the group ending 2^l below it. Updated in place; the partner
  // position is never written within the same level.
  always_comb begin : up_sweep
    logic [1:0] gp;
    g_up = g_in;
    p_up = p_in;
    gp   = 2'b00;
    for (int l = 0; l < LVLS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          gp      = pg_op(g_up[i], p_up[i], g_up[i-(1<<l)], p_up[i-(1<<l)]);
          g_up[i] = gp[1];
          p_up[i] = gp[0];
        end
      end
    end
  end

  // Down-sweep: fill in the positions midway between completed prefixes,
  // widest spacing first, so every position ends up holding prefix [i:0].
  always_comb begin : down_sweep
    logic [1:0] gp;
    g_pre = g_mid;
    p_pre = p_mid;
    gp    = 2'b00;
    for (int l = LVLS - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i > (1 << l))) begin
          gp       = pg_op(g_pre[i], p_pre[i], g_pre[i-(1<<l)], p_pre[i-(1<<l)]);
          g_pre[i] = gp[1];
          p_pre[i] = gp[0];
        end
      end
    end
  end

endmodule

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung adder/subtractor with valid/ready on both sides.
// Latency 2+REG_MID cycles; throughput one beat per cycle.
// Backpressure ripples combinationally from out_ready to in_ready; empty stages always load.
module bk_adder_pipe
  import bk_adder_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REG_MID = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("bk_adder_pipe: WIDTH must be a power of two between 4 and 128");
  end

  // Operand conditioning: subtraction is A + ~B + ~borrow.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  assign is_sub = (op_e'(in_sub) == OP_SUB);
  assign b_eff  = is_sub ? ~in_b : in_b;
  assign c0_in  = is_sub ? ~in_cin : in_cin;

  // Stage S0 state
  logic             s0_v;
  logic [WIDTH-1:0] s0_p;
  logic [WIDTH-1:0] s0_g;
  logic             s0_c0;

  // Mid boundary (registered or straight through)
  logic             mid_v;
  logic [WIDTH-1:0] mid_g;
  logic [WIDTH-1:0] mid_p;
  logic [WIDTH-1:0] mid_bp;
  logic             mid_c0;

  logic             out_ld;
  logic             adv_s0;
  logic [WIDTH-1:0] up_g;
  logic [WIDTH-1:0] up_p;
  logic [WIDTH-1:0] pre_g;
  logic [WIDTH-1:0] pre_p;
  logic [WIDTH:0]   carry;

  // Output register loads whenever it is empty or being drained.
  assign out_ld   = !out_valid || out_ready;
  assign in_ready = !s0_v || adv_s0;

  // S0: capture bitwise propagate/generate and the effective carry-in on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v  <= 1'b0;
      s0_p  <= '0;
      s0_g  <= '0;
      s0_c0 <= 1'b0;
    end else if (in_ready) begin
      s0_v <= in_valid;
      if (in_valid) begin
        s0_p  <= in_a ^ b_eff;
        s0_g  <= in_a & b_eff;
        s0_c0 <= c0_in;
      end
    end
  end

  bk_prefix_tree #(
    .WIDTH(WIDTH)
  ) u_tree (
    .g_in (s0_g),
    .p_in (s0_p),
    .g_up (up_g),
    .p_up (up_p),
    .g_mid(mid_g),
    .p_mid(mid_p),
    .g_pre(pre_g),
    .p_pre(pre_p)
  );

  if (REG_MID != 0) begin : g_mid_reg
    logic             s1_v;
    logic [WIDTH-1:0] s1_g;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_bp;
    logic             s1_c0;

    // S1: hold the up-sweep group terms plus what the sum stage still needs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v  <= 1'b0;
        s1_g  <= '0;
        s1_p  <= '0;
        s1_bp <= '0;
        s1_c0 <= 1'b0;
      end else if (!s1_v || out_ld) begin
        s1_v <= s0_v;
        if (s0_v) begin
          s1_g  <= up_g;
          s1_p  <= up_p;
          s1_bp <= s0_p;
          s1_c0 <= s0_c0;
        end
      end
    end

    assign adv_s0 = !s1_v || out_ld;
    assign mid_v  = s1_v;
    assign mid_g  = s1_g;
    assign mid_p  = s1_p;
    assign mid_bp = s1_bp;
    assign mid_c0 = s1_c0;
  end else begin : g_mid_wire
    assign adv_s0 = out_ld;
    assign mid_v  = s0_v;
    assign mid_g  = up_g;
    assign mid_p  = up_p;
    assign mid_bp = s0_p;
    assign mid_c0 = s0_c0;
  end

  // Carry into bit i+1 is the prefix [i:0] applied to the carry-in.
  assign carry = {pre_g | (pre_p & {WIDTH{mid_c0}}), mid_c0};

  // Output stage: sum, carry-out and signed overflow, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (out_ld) begin
      out_valid <= mid_v;
      if (mid_v) begin
        out_sum  <= mid_bp ^ carry[WIDTH-1:0];
        out_cout <= carry[WIDTH];
        out_ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
      end
    end
  end

endmodule
